// File: rtl/fare_disp_pkg.sv
// Shared constants and state encoding for the fare display binary-to-BCD path.
package fare_disp_pkg;

  localparam int unsigned DIGITS  = 6;
  localparam int unsigned BCD_W   = 4 * DIGITS;
  localparam logic [19:0] BCD_MAX = 20'd999_999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/fare_bin2bcd_if.sv
// Request/result bundle between the billing logic (master) and the BCD converter (slave).
interface fare_bin2bcd_if #(
  parameter int unsigned DATA_W = 20
);

  logic [DATA_W-1:0] data_in;
  logic              data_vld;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [3:0]        unit;
  logic [3:0]        ten;
  logic [3:0]        hun;
  logic [3:0]        tho;
  logic [3:0]        t_tho;
  logic [3:0]        h_tho;
  logic              seg_on;

  modport master (
    output data_in, data_vld,
    input  busy, done, ovf, unit, ten, hun, tho, t_tho, h_tho, seg_on
  );

  modport slave (
    input  data_in, data_vld,
    output busy, done, ovf, unit, ten, hun, tho, t_tho, h_tho, seg_on
  );

endinterface

// File: rtl/bcd_add3.sv
// Per-nibble shift-and-add-3 correction; never carries into the next nibble.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] corr
);

  always_comb begin
    corr = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

endmodule

// File: rtl/fare_bin2bcd.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the six-digit fare display.
// Optional feature: FARE_BCD_CLAMP_EN clamps inputs above 999_999 instead of rejecting them.
module fare_bin2bcd
  import fare_disp_pkg::*;
#(
  parameter int unsigned DATA_W = 20
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  fare_bin2bcd_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_e                     state_q, state_d;
  logic [DATA_W-1:0]          bin_q, bin_d;
  logic [BCD_W-1:0]           bcd_q, bcd_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [BCD_W-1:0]           dig_q, dig_d;
  logic                       done_q, done_d;
  logic                       ovf_q, ovf_d;
  logic                       seg_on_q, seg_on_d;
  logic                       clamp_q, clamp_d;

  logic [BCD_W-1:0]           bcd_adj;
  logic [BCD_W+DATA_W-1:0]    shifted;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .nib  (bcd_q[4*i +: 4]),
      .corr (bcd_adj[4*i +: 4])
    );
  end

  assign shifted = {bcd_adj, bin_q} << 1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      dig_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      seg_on_q <= 1'b0;
      clamp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      seg_on_q <= seg_on_d;
      clamp_q  <= clamp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    dig_d    = dig_q;
    done_d   = 1'b0;
    ovf_d    = 1'b0;
    seg_on_d = seg_on_q;
    clamp_d  = clamp_q;

    unique case (state_q)
      IDLE: begin
        if (bus.data_vld) begin
          if (bus.data_in > DATA_W'(BCD_MAX)) begin
`ifdef FARE_BCD_CLAMP_EN
            bin_d   = DATA_W'(BCD_MAX);
            clamp_d = 1'b1;
            bcd_d   = '0;
            cnt_d   = CNT_W'(DATA_W);
            state_d = SHIFT;
`else
            ovf_d   = 1'b1;
`endif
          end else begin
            bin_d   = bus.data_in;
            clamp_d = 1'b0;
            bcd_d   = '0;
            cnt_d   = CNT_W'(DATA_W);
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_d = shifted[BCD_W+DATA_W-1:DATA_W];
        bin_d = shifted[DATA_W-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          // Outputs take the final step's result directly so they are valid in the DONE cycle.
          state_d  = DONE;
          dig_d    = shifted[BCD_W+DATA_W-1:DATA_W];
          done_d   = 1'b1;
          ovf_d    = clamp_q;
          seg_on_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.ovf    = ovf_q;
  assign bus.seg_on = seg_on_q;
  assign bus.unit   = dig_q[3:0];
  assign bus.ten    = dig_q[7:4];
  assign bus.hun    = dig_q[11:8];
  assign bus.tho    = dig_q[15:12];
  assign bus.t_tho  = dig_q[19:16];
  assign bus.h_tho  = dig_q[23:20];

endmodule
